branch_prediction_unit: RTL

- Parametrised dynamic branch predictor feeding the fetch-stage PC-select logic.
- Holds a pattern history table (PHT) of saturating counters and a global history register (GHR).
- Gives a taken/not-taken prediction for the fetch PC in the same cycle, and trains the PHT with the execute-stage resolution.
- Restores the speculatively-updated GHR on a mispredict and signals the mispredict to the PC-select logic.

---
 rtl/branch_pred_pkg.sv | 28 ++
 rtl/branch_prediction_unit_pht_ram.sv | 26 ++
 rtl/branch_prediction_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/branch_pred_pkg.sv
// Shared types and counter helpers for the branch predictor: FSM states,
// counter initialisation value and saturating counter update.
package branch_pred_pkg;

  typedef enum logic {PRED_INIT, PRED_RUN} pred_state_t;

  // Widest counter the helpers handle; callers truncate to their CTR_W.
  localparam int CTR_MAX_W = 16;

  // Weakly not-taken: 2^(ctr_w-1)-1, which is 0 for a 1-bit counter.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input int ctr_w);
    logic [CTR_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < ctr_w - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_update(input logic [CTR_MAX_W-1:0] ctr,
                                                      input logic taken,
                                                      input int ctr_w);
    logic [CTR_MAX_W-1:0] top;
    top = '0;
    for (int i = 0; i < ctr_w; i++) top[i] = 1'b1;
    if (taken) return (ctr == top) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/branch_prediction_unit_pht_ram.sv
// Pattern history table storage: ENTRIES x CTR_W counters, one synchronous
// write port, asynchronous read ports for the fetch lookup and the EX train.
module pht_ram #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic [CTR_W-1:0]           wr_data,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic [CTR_W-1:0]           rd_data,
  input  logic [$clog2(ENTRIES)-1:0] trn_idx,
  output logic [CTR_W-1:0]           trn_data
);

  logic [CTR_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data  = mem[rd_idx];
  assign trn_data = mem[trn_idx];

endmodule

// File: rtl/branch_prediction_unit.sv
// Dynamic branch predictor: PHT of saturating counters plus optional gshare
// global history (enable with macro BRANCH_PRED_GSHARE_EN; bimodal otherwise).
module branch_prediction_unit
  import branch_pred_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [WIDTH-1:0]           pc_fi_i,
  input  logic                       branch_fi_i,
  input  logic                       stall_fi_i,
  output logic                       pred_taken_fi_o,
  output logic [$clog2(ENTRIES)-1:0] pred_idx_fi_o,
  output logic [HIST_W-1:0]          ghr_snap_fi_o,
  input  logic                       branch_ex_i,
  input  logic                       pred_taken_ex_i,
  input  logic [$clog2(ENTRIES)-1:0] pred_idx_ex_i,
  input  logic [HIST_W-1:0]          ghr_snap_ex_i,
  input  logic                       taken_res_ex_i,
  output logic                       mispredict_ex_o,
  output logic                       ready_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init(CTR_W));

  pred_state_t      state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic             init_we;
  logic             we;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;
  logic [CTR_W-1:0] rd_data;
  logic [CTR_W-1:0] trn_data;
  logic [IDX_W-1:0] idx;
  logic             unused_pc;

  assign unused_pc = ^{pc_fi_i[WIDTH-1:IDX_W+2], pc_fi_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= PRED_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    init_we   = 1'b0;
    if (state == PRED_INIT) begin
      init_we = 1'b1;
      ptr_nxt = ptr + 1'b1;
      if (ptr == IDX_W'(ENTRIES - 1)) state_nxt = PRED_RUN;
    end
  end

  assign ready_o = (state == PRED_RUN);

  // The init sweep owns the write port until the table is ready.
  always_comb begin
    we      = init_we | (branch_ex_i & ready_o);
    wr_idx  = pred_idx_ex_i;
    wr_data = CTR_W'(sat_update(CTR_MAX_W'(trn_data), taken_res_ex_i, CTR_W));
    if (init_we) begin
      wr_idx  = ptr;
      wr_data = INIT_VAL;
    end
  end

  assign mispredict_ex_o = branch_ex_i & (pred_taken_ex_i != taken_res_ex_i);

`ifdef BRANCH_PRED_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  ghr_ext;

  function automatic logic [HIST_W-1:0] hist_push(input logic [HIST_W-1:0] h,
                                                  input logic b);
    logic [HIST_W:0] t;
    t = {h, b};
    return t[HIST_W-1:0];
  endfunction

  // A mispredict rebuilds history from the EX snapshot; the fetch beat is wrong-path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr <= '0;
    end else if (ready_o) begin
      if (mispredict_ex_o)
        ghr <= hist_push(ghr_snap_ex_i, taken_res_ex_i);
      else if (branch_fi_i && !stall_fi_i)
        ghr <= hist_push(ghr, pred_taken_fi_o);
    end
  end

  always_comb begin
    ghr_ext              = '0;
    ghr_ext[HIST_W-1:0]  = ghr;
  end

  assign idx           = pc_fi_i[IDX_W+1:2] ^ ghr_ext;
  assign ghr_snap_fi_o = ghr;
`else
  logic unused_hist;

  assign unused_hist   = ^{ghr_snap_ex_i, branch_fi_i, stall_fi_i};
  assign idx           = pc_fi_i[IDX_W+1:2];
  assign ghr_snap_fi_o = '0;
`endif

  assign pred_idx_fi_o   = idx;
  assign pred_taken_fi_o = ready_o & rd_data[CTR_W-1];

  pht_ram #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W)
  ) u_pht (
    .clk      (clk_i),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_idx   (idx),
    .rd_data  (rd_data),
    .trn_idx  (pred_idx_ex_i),
    .trn_data (trn_data)
  );

endmodule
